// File: rtl/spi_burst_pkg.sv
// spi_burst_pkg: shared types and constants for the SPI burst read engine.
//   - state_e   : engine state encoding (IDLE, ADDR, DATA, GAP)
//   - bl_width  : width of the burst length field for a given BURST_MAX
//   - LSB_FIRST : serial bit order for both address and data
// Configuration macro: SPI_BURST_LSB_FIRST_EN
//   defined   -> address and data are shifted LSB-first
//   undefined -> MSB-first (default)
package spi_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Enough bits to hold the values 0..burst_max.
    function automatic int bl_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

`ifdef SPI_BURST_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/spi_burst_reader_shift_reg.sv
// spi_shift_reg: parametrised shift register with parallel load.
// Used both as a parallel-in/serial-out address shifter and as a
// serial-in/parallel-out data deserialiser.
// Ports:
//   spi_clk, n_reset : clock (posedge), async active-low reset
//   load_i           : load load_val_i (has priority over shift_i)
//   load_val_i       : parallel load value
//   shift_i          : shift one position, ser_i entering at the far end
//   ser_i            : serial input bit
//   ser_o            : bit currently at the output end
//   par_o            : current register contents
//   shifted_o        : contents after one shift with the present ser_i
//                      (lets the caller capture a completed word on the
//                      same edge that samples its final bit)
// Direction: LSB_FIRST=0 shifts toward the MSB (ser_o is the MSB);
//            LSB_FIRST=1 shifts toward the LSB (ser_o is bit 0).
module spi_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             spi_clk,
    input  logic             n_reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] par_o,
    output logic [WIDTH-1:0] shifted_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d    = LSB_FIRST ? {ser_i, data_q[WIDTH-1:1]}
                                 : {data_q[WIDTH-2:0], ser_i};
    assign shifted_o = data_d;
    assign ser_o     = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign par_o     = data_q;

    always_ff @(posedge spi_clk or negedge n_reset) begin
        if (!n_reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_val_i;
        end else if (shift_i) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/spi_burst_reader.sv
// spi_burst_reader: SPI master-side burst read engine clocked by spi_clk.
// Frames a transaction with spi_cs_n, shifts an ASIZE-bit address out on
// spi_mosi, then samples burst_len DSIZE-bit words from spi_miso into a
// one-entry valid/ready output buffer with sticky overrun detection.
// Configuration macro: SPI_BURST_LSB_FIRST_EN (LSB-first bit order when
// defined, MSB-first otherwise; see spi_burst_pkg).
// Ports:
//   spi_clk, n_reset  : clock (posedge), async active-low reset
//   start_i           : request, accepted only in IDLE (wins over abort_i)
//   abort_i           : terminate the transaction (ADDR/DATA only)
//   addr_i            : address, latched on accept
//   burst_len_i       : word count, latched on accept (0 -> 1, >MAX -> MAX)
//   spi_cs_n_o        : chip select, active low
//   spi_mosi_o        : serial address out
//   spi_miso_i        : serial data in
//   rx_data_o         : received word
//   rx_valid_o        : rx_data_o holds an unconsumed word
//   rx_ready_i        : consumer takes rx_data_o
//   busy_o            : engine not idle
//   done_o            : one-cycle pulse on normal completion
//   overrun_o         : sticky, an unconsumed word was overwritten
//   state_o           : current engine state (spi_burst_pkg::state_e)
// Handshake: a word transfers on any posedge where rx_valid_o and
// rx_ready_i are both high; rx_valid_o stays high until that happens, and
// a new word arriving while rx_valid_o is high and rx_ready_i is low
// replaces the buffered word and sets overrun_o.
module spi_burst_reader
    import spi_burst_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 8,
    parameter int BURST_MAX = 4,
    parameter int BL_W      = bl_width(BURST_MAX)
) (
    input  logic             spi_clk,
    input  logic             n_reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ASIZE-1:0] addr_i,
    input  logic [BL_W-1:0]  burst_len_i,
    output logic             spi_cs_n_o,
    output logic             spi_mosi_o,
    input  logic             spi_miso_i,
    output logic [DSIZE-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o,
    output logic [1:0]       state_o
);

    // One counter serves both the address phase and the per-word sample count.
    localparam int CNT_MAX = (ASIZE > DSIZE) ? ASIZE : DSIZE;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_e            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [BL_W-1:0]   word_cnt_q;
    logic [BL_W-1:0]   len_q;
    logic              cs_n_q;
    logic [DSIZE-1:0]  rx_data_q;
    logic              rx_valid_q;
    logic              done_q;
    logic              overrun_q;

    logic              accept;
    logic              addr_ser;
    logic [ASIZE-1:0]  addr_par;
    logic [ASIZE-1:0]  addr_shifted;
    logic              data_ser;
    logic [DSIZE-1:0]  data_par;
    logic [DSIZE-1:0]  word_d;
    logic              unused_shift_bits;

    function automatic logic [BL_W-1:0] clamp_len(input logic [BL_W-1:0] len);
        if (len == '0) begin
            return BL_W'(1);
        end
        if (int'(len) > BURST_MAX) begin
            return BL_W'(BURST_MAX);
        end
        return len;
    endfunction

    assign accept = (state_q == ST_IDLE) && start_i;

    spi_shift_reg #(
        .WIDTH     (ASIZE),
        .LSB_FIRST (LSB_FIRST)
    ) u_addr_sr (
        .spi_clk    (spi_clk),
        .n_reset    (n_reset),
        .load_i     (accept),
        .load_val_i (addr_i),
        .shift_i    (state_q == ST_ADDR),
        .ser_i      (1'b0),
        .ser_o      (addr_ser),
        .par_o      (addr_par),
        .shifted_o  (addr_shifted)
    );

    // Samples MISO on every DATA edge; word_d is the word including the
    // bit being sampled on this edge.
    spi_shift_reg #(
        .WIDTH     (DSIZE),
        .LSB_FIRST (LSB_FIRST)
    ) u_data_sr (
        .spi_clk    (spi_clk),
        .n_reset    (n_reset),
        .load_i     (accept),
        .load_val_i ({DSIZE{1'b0}}),
        .shift_i    ((state_q == ST_DATA) && !abort_i),
        .ser_i      (spi_miso_i),
        .ser_o      (data_ser),
        .par_o      (data_par),
        .shifted_o  (word_d)
    );

    assign unused_shift_bits = ^{addr_par, addr_shifted, data_ser, data_par};

    always_ff @(posedge spi_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            len_q      <= BL_W'(1);
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Consumer handshake; a word completing on this same edge
            // re-sets rx_valid below.
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q      <= clamp_len(burst_len_i);
                        overrun_q  <= 1'b0;
                        cs_n_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (abort_i) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_GAP;
                    end else if (bit_cnt_q == CNT_W'(ASIZE - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    // Abort beats a word completing on the same edge.
                    if (abort_i) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_GAP;
                    end else if (bit_cnt_q == CNT_W'(DSIZE - 1)) begin
                        bit_cnt_q  <= '0;
                        rx_data_q  <= word_d;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rx_ready_i) begin
                            overrun_q <= 1'b1;
                        end
                        if (word_cnt_q == len_q - BL_W'(1)) begin
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_GAP;
                        end else begin
                            word_cnt_q <= word_cnt_q + BL_W'(1);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The address shifter only drives the line while in ADDR, so MOSI
    // returns to 0 on entry to DATA and whenever the engine is not addressing.
    assign spi_mosi_o = (state_q == ST_ADDR) && addr_ser;
    assign spi_cs_n_o = cs_n_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_spi_burst_reader.sv
// tb_spi_burst_reader: self-checking bench for spi_burst_reader.
// Expected words are pushed into exp_q when a transaction is issued; a
// monitor pops and compares on every rx_valid/rx_ready handshake. Per-cycle
// pin expectations come from edge arithmetic on the transaction parameters.
module tb_spi_burst_reader;

    localparam int DSIZE     = 8;
    localparam int ASIZE     = 8;
    localparam int BURST_MAX = 4;
    localparam int BL_W      = $clog2(BURST_MAX + 1);

`ifdef SPI_BURST_LSB_FIRST_EN
    localparam bit TB_LSB = 1'b1;
`else
    localparam bit TB_LSB = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             spi_clk     = 1'b0;
    logic             n_reset     = 1'b0;
    logic             start_i     = 1'b0;
    logic             abort_i     = 1'b0;
    logic [ASIZE-1:0] addr_i      = '0;
    logic [BL_W-1:0]  burst_len_i = '0;
    logic             spi_miso_i  = 1'b0;
    logic             rx_ready_i  = 1'b0;
    logic             spi_cs_n_o;
    logic             spi_mosi_o;
    logic [DSIZE-1:0] rx_data_o;
    logic             rx_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             overrun_o;
    logic [1:0]       state_o;

    always #5 spi_clk = ~spi_clk;

    spi_burst_reader #(
        .DSIZE     (DSIZE),
        .ASIZE     (ASIZE),
        .BURST_MAX (BURST_MAX),
        .BL_W      (BL_W)
    ) dut (
        .spi_clk     (spi_clk),
        .n_reset     (n_reset),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .addr_i      (addr_i),
        .burst_len_i (burst_len_i),
        .spi_cs_n_o  (spi_cs_n_o),
        .spi_mosi_o  (spi_mosi_o),
        .spi_miso_i  (spi_miso_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o),
        .state_o     (state_o)
    );

    // ---------------- scoreboard state ----------------
    int               n_total = 0;
    int               n_pass  = 0;
    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] txn_words[BURST_MAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int n_words(input int len);
        if (len == 0) return 1;
        if (len > BURST_MAX) return BURST_MAX;
        return len;
    endfunction

    function automatic logic addr_bit(input logic [ASIZE-1:0] a, input int k);
        return TB_LSB ? a[k] : a[ASIZE-1-k];
    endfunction

    // s = 0-based index of the MISO sample within the whole burst
    function automatic logic miso_bit(input int s);
        logic [DSIZE-1:0] w;
        int               idx;
        w   = txn_words[s / DSIZE];
        idx = s % DSIZE;
        return TB_LSB ? w[idx] : w[DSIZE-1-idx];
    endfunction

    // Words completed on edges E1..Ee, word w completing at E(ASIZE+(w+1)*DSIZE),
    // excluding any completion on or after an abort edge.
    function automatic int completions(input int n, input int e, input int abort_at);
        int c;
        c = 0;
        for (int w = 0; w < n; w++) begin
            int ce;
            ce = ASIZE + (w + 1) * DSIZE;
            if (ce <= e && (abort_at == 0 || ce < abort_at)) c++;
        end
        return c;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [DSIZE-1:0] exp_word;
        forever begin
            @(negedge spi_clk);
            if (n_reset && rx_valid_o && rx_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rx_unexpected: got word %0h, expected no word at t=%0t", rx_data_o, $time);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("rx_data", rx_data_o, exp_word);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge spi_clk);
        #1;
    endtask

    // abort_at = 0: no abort; otherwise abort is sampled at edge E(abort_at).
    task automatic run_txn(input logic [ASIZE-1:0] a, input int len, input bit rdy, input int abort_at);
        int n, fin, k, comps, s;
        bit aborted;
        n       = n_words(len);
        aborted = (abort_at != 0);
        fin     = aborted ? abort_at : ASIZE + n * DSIZE;
        k       = completions(n, fin, abort_at);
        if (rdy) begin
            for (int w = 0; w < k; w++) exp_q.push_back(txn_words[w]);
        end

        addr_i      = a;
        burst_len_i = BL_W'(len);
        rx_ready_i  = rdy;
        start_i     = 1'b1;
        abort_i     = 1'($urandom_range(0, 1));   // start beats abort in IDLE
        step();                                   // E0
        start_i = 1'b0;
        abort_i = 1'b0;

        for (int e = 0; e <= fin + 1; e++) begin
            comps = completions(n, e, abort_at);
            check("cs_n", spi_cs_n_o, (e < fin) ? 1'b0 : 1'b1);
            if (e < fin && e <= ASIZE)
                check("mosi", spi_mosi_o, (e < ASIZE) ? addr_bit(a, e) : 1'b0);
            check("done", done_o, (!aborted && e == fin));
            check("busy", busy_o, (e <= fin));
            check("overrun", overrun_o, (!rdy && comps >= 2));
            if (e <= fin) begin
                s          = e + 1 - (ASIZE + 1);
                spi_miso_i = (s >= 0 && s < n * DSIZE) ? miso_bit(s) : 1'($urandom_range(0, 1));
                if (e + 1 == abort_at) abort_i = 1'b1;
                else if (e == fin)     abort_i = 1'($urandom_range(0, 1));  // GAP: ignored
                else                   abort_i = 1'b0;
                start_i = 1'($urandom_range(0, 1));                         // busy: ignored
                step();
            end
        end
        start_i = 1'b0;
        abort_i = 1'b0;

        if (!rdy && k > 0) begin
            check("buf_valid", rx_valid_o, 1'b1);
            check("buf_data", rx_data_o, txn_words[k-1]);
            exp_q.push_back(txn_words[k-1]);
            rx_ready_i = 1'b1;
            step();
            step();
            check("overrun_sticky", overrun_o, (k >= 2));
        end
        check("rx_drained", rx_valid_o, 1'b0);
        check("q_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        check("rst_cs_n", spi_cs_n_o, 1'b1);
        check("rst_mosi", spi_mosi_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rx_valid", rx_valid_o, 1'b0);
        check("rst_rx_data", rx_data_o, 0);
        @(posedge spi_clk);
        #3 n_reset = 1'b1;
        step();
        check("rst_state", state_o, 0);
        check("rst_overrun", overrun_o, 1'b0);

        // single word, MSB-first address 85 / data A5
        txn_words[0] = 8'hA5;
        run_txn(8'h85, 1, 1'b1, 0);

        // three words with a ready consumer
        txn_words[0] = 8'h11; txn_words[1] = 8'h22; txn_words[2] = 8'h33;
        run_txn(8'h5A, 3, 1'b1, 0);

        // two words, consumer stalled -> overrun, buffer holds word 1
        txn_words[0] = 8'h3C; txn_words[1] = 8'hC3;
        run_txn(8'hF0, 2, 1'b0, 0);

        // abort during bit 3 of word 1: buffer keeps word 0 only
        txn_words[0] = 8'h96; txn_words[1] = 8'h69;
        run_txn(8'h0F, 2, 1'b0, ASIZE + 1 + DSIZE + 3);

        // burst_len clamping
        txn_words[0] = 8'h7E;
        run_txn(8'h81, 0, 1'b1, 0);
        for (int w = 0; w < BURST_MAX; w++) txn_words[w] = DSIZE'($urandom);
        run_txn(8'h42, (1 << BL_W) - 1, 1'b1, 0);

        // async reset in the middle of ADDR
        addr_i     = 8'h3C;
        burst_len_i = BL_W'(1);
        rx_ready_i = 1'b1;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        #2 n_reset = 1'b0;
        #1;
        check("mid_rst_cs_n", spi_cs_n_o, 1'b1);
        check("mid_rst_mosi", spi_mosi_o, 1'b0);
        check("mid_rst_rx_data", rx_data_o, 0);
        check("mid_rst_rx_valid", rx_valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_overrun", overrun_o, 1'b0);
        check("mid_rst_state", state_o, 0);
        @(posedge spi_clk);
        #3 n_reset = 1'b1;
        step();
        txn_words[0] = 8'hE1;
        run_txn(8'hC7, 1, 1'b1, 0);

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            int len, n, ab;
            bit rdy;
            len = $urandom_range(0, BURST_MAX + 1);
            n   = n_words(len);
            rdy = 1'($urandom_range(0, 1));
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ASIZE + n * DSIZE - 1) : 0;
            for (int w = 0; w < BURST_MAX; w++) txn_words[w] = DSIZE'($urandom);
            run_txn(ASIZE'($urandom), len, rdy, ab);
            for (int i = 0; i < $urandom_range(0, 3); i++) begin
                abort_i = 1'($urandom_range(0, 1));     // IDLE: ignored
                step();
            end
            abort_i = 1'b0;
        end

        check("final_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
